// File: rtl/alu_mc_pkg.sv
// Shared opcode and FSM encodings for the multi-cycle ALU.
package alu_mc_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_SHL = 4'b0100;
    localparam logic [3:0] OP_SHR = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_OR  = 4'b1000;
    localparam logic [3:0] OP_XOR = 4'b1001;
    localparam logic [3:0] OP_SLT = 4'b1010;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

endpackage

// File: rtl/alu_mc_mul.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle.
module alu_mc_mul #(
    parameter int Width    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [Width-1:0]     a,
    input  logic [Width-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*Width-1:0]   product
);

    localparam int N  = Width / MUL_STEP;
    localparam int CW = $clog2(N) + 1;

    logic [Width-1:0]   mcand;
    logic [2*Width-1:0] acc;
    logic [2*Width-1:0] acc_nxt;
    logic [CW-1:0]      cnt;

    // Multiplier digits sit in the low half and are consumed as the accumulator shifts right.
    function automatic logic [2*Width-1:0] mul_step(input logic [2*Width-1:0] acc_i,
                                                    input logic [Width-1:0]   m);
        logic [Width+MUL_STEP-1:0]   sum;
        logic [2*Width+MUL_STEP-1:0] wide;
        sum  = {{MUL_STEP{1'b0}}, acc_i[2*Width-1:Width]}
             + {{MUL_STEP{1'b0}}, m} * {{Width{1'b0}}, acc_i[MUL_STEP-1:0]};
        wide = {sum, acc_i[Width-1:0]};
        return wide[2*Width+MUL_STEP-1:MUL_STEP];
    endfunction

    assign acc_nxt = mul_step(acc, mcand);
    assign product = acc_nxt;
    assign done    = busy & (cnt == CW'(1));

    // The first digit is retired on the start edge, so N-1 busy cycles remain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CW'(N - 1);
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1))
                busy <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            mcand <= a;
            acc   <= mul_step({{Width{1'b0}}, b}, a);
        end else if (busy) begin
            acc <= acc_nxt;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Handshaked multi-cycle integer ALU: single-cycle ops plus an iterative multiply.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int Width    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       control,
    input  logic [Width-1:0] operand1,
    input  logic [Width-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_ovf,
    output logic             err
);

    localparam int SW = $clog2(Width);

    logic [1:0]          state;
    logic                accept;
    logic                is_mul;
    logic                illegal;
    logic                mul_busy;
    logic                mul_done;
    logic [2*Width-1:0]  product;
    logic [Width-1:0]    res;
    logic                res_c;
    logic                res_v;
    logic [Width:0]      add_w;
    logic [Width:0]      sub_w;
    logic [SW-1:0]       shamt;
    logic                shbig;
    logic signed [Width-1:0] a_s;
    logic signed [Width-1:0] b_s;

    assign in_ready  = (state == IDLE) | ((state == HOLD) & out_ready);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid & in_ready;
    assign is_mul    = (control == OP_MUL);

    assign a_s   = operand1;
    assign b_s   = operand2;
    assign add_w = {1'b0, operand1} + {1'b0, operand2};
    assign sub_w = {1'b0, operand1} - {1'b0, operand2};
    assign shamt = operand2[SW-1:0];
    assign shbig = |(operand2 >> SW);

    always_comb begin
        res     = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        illegal = 1'b0;
        unique case (control)
            OP_ADD: begin
                res   = add_w[Width-1:0];
                res_c = add_w[Width];
                res_v = (operand1[Width-1] == operand2[Width-1]) &&
                        (add_w[Width-1] != operand1[Width-1]);
            end
            OP_SUB: begin
                res   = sub_w[Width-1:0];
                res_c = sub_w[Width];
                res_v = (operand1[Width-1] != operand2[Width-1]) &&
                        (sub_w[Width-1] != operand1[Width-1]);
            end
            OP_MUL: res = '0;
            OP_SHL: res = shbig ? '0 : operand1 << shamt;
            OP_SHR: res = shbig ? '0 : operand1 >> shamt;
            OP_SRA: res = shbig ? {Width{operand1[Width-1]}} : a_s >>> shamt;
            OP_AND: res = operand1 & operand2;
            OP_OR:  res = operand1 | operand2;
            OP_XOR: res = operand1 ^ operand2;
            OP_SLT: res[0] = (a_s < b_s);
            default: illegal = 1'b1;
        endcase
    end

    alu_mc_mul #(
        .Width   (Width),
        .MUL_STEP(MUL_STEP)
    ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (accept & is_mul),
        .a      (operand1),
        .b      (operand2),
        .busy   (mul_busy),
        .done   (mul_done),
        .product(product)
    );

    // Result registers only move on the edge that enters HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            out        <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            flag_ovf   <= 1'b0;
            err        <= 1'b0;
        end else if (accept) begin
            if (is_mul) begin
                state <= BUSY;
            end else begin
                state      <= HOLD;
                out        <= res;
                flag_zero  <= ~illegal & ~|res;
                flag_carry <= res_c;
                flag_ovf   <= res_v;
                err        <= illegal;
            end
        end else if ((state == BUSY) && mul_busy && mul_done) begin
            state      <= HOLD;
            out        <= product[Width-1:0];
            flag_zero  <= ~|product[Width-1:0];
            flag_carry <= |product[2*Width-1:Width];
            flag_ovf   <= 1'b0;
            err        <= 1'b0;
        end else if ((state == HOLD) && out_ready) begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc with a scoreboard model of the ALU result rules.
module tb_alu_mc;

    localparam logic [3:0] ADD = 4'd1, SUB = 4'd2, MUL = 4'd3, SHL = 4'd4, SHR = 4'd5;
    localparam logic [3:0] SRA = 4'd6, AND_ = 4'd7, OR_ = 4'd8, XOR_ = 4'd9, SLT = 4'd10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  control;
    logic [31:0] operand1, operand2, out;
    logic        flag_zero, flag_carry, flag_ovf, err;

    logic        in_valid4, in_ready4, out_valid4;
    logic [3:0]  control4;
    logic [31:0] operand1_4, operand2_4, out4;
    logic        zero4, carry4, ovf4, err4;

    int nvec  = 0;
    int nfail = 0;

    typedef struct packed {
        logic [31:0] o;
        logic        z, c, v, e;
    } res_t;
    res_t q[$];

    always #5 clk = ~clk;

    alu_mc #(.Width(32), .MUL_STEP(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .control(control), .operand1(operand1), .operand2(operand2),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_ovf(flag_ovf), .err(err)
    );

    alu_mc #(.Width(32), .MUL_STEP(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .control(control4), .operand1(operand1_4), .operand2(operand2_4),
        .out_valid(out_valid4), .out_ready(1'b1), .out(out4),
        .flag_zero(zero4), .flag_carry(carry4), .flag_ovf(ovf4), .err(err4)
    );

    function automatic res_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        res_t r;
        longint unsigned ua, ub, w;
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = '0;
        case (op)
            ADD: begin
                w = ua + ub;
                r.o = w[31:0];
                r.c = (w >= 64'h1_0000_0000);
                r.v = (a[31] == b[31]) && (r.o[31] != a[31]);
            end
            SUB: begin
                r.o = a - b;
                r.c = (ua < ub);
                r.v = (a[31] != b[31]) && (r.o[31] != a[31]);
            end
            MUL: begin
                w = ua * ub;
                r.o = w[31:0];
                r.c = (w[63:32] != 32'd0);
            end
            SHL:  r.o = (ub >= 32) ? 32'd0 : a << ub;
            SHR:  r.o = (ub >= 32) ? 32'd0 : a >> ub;
            SRA:  r.o = (ub >= 32) ? {32{a[31]}} : 32'($signed(a) >>> ub);
            AND_: r.o = a & b;
            OR_:  r.o = a | b;
            XOR_: r.o = a ^ b;
            SLT:  r.o = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r.e = 1'b1;
        endcase
        r.z = !r.e && (r.o == 32'd0);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every cycle with out_valid is compared against the oldest accepted op.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected out_valid", 64'(out_valid), 64'd0);
                end else begin
                    chk("scoreboard", {27'd0, out, flag_zero, flag_carry, flag_ovf, err},
                        {27'd0, q[0].o, q[0].z, q[0].c, q[0].v, q[0].e});
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) q.push_back(model(control, operand1, operand2));
        end
    end

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        control  = op;
        operand1 = a;
        operand2 = b;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            guard++;
            if (guard > 200) begin
                chk("accept timeout", 64'(in_ready), 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // lat counts edges from the accepting edge to the one that raises out_valid (inclusive).
    task automatic wait_out(output int lat, output int rdy_hi);
        lat    = 1;
        rdy_hi = 0;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_hi++;
            @(posedge clk);
            #1 lat++;
        end
        if (!out_valid) chk("out_valid timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic lit(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eo, input logic ez,
                       input logic ec, input logic ev, input logic ee, input int elat);
        int lat, rdy_hi;
        send(op, a, b);
        wait_out(lat, rdy_hi);
        chk({name, " out"},   64'(out),        64'(eo));
        chk({name, " zero"},  64'(flag_zero),  64'(ez));
        chk({name, " carry"}, 64'(flag_carry), 64'(ec));
        chk({name, " ovf"},   64'(flag_ovf),   64'(ev));
        chk({name, " err"},   64'(err),        64'(ee));
        chk({name, " latency"}, 64'(lat), 64'(elat));
        if (op == MUL) chk({name, " in_ready while busy"}, 64'(rdy_hi), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        in_valid = 1'b0; control = 4'd0; operand1 = '0; operand2 = '0; out_ready = 1'b1;
        in_valid4 = 1'b0; control4 = 4'd0; operand1_4 = '0; operand2_4 = '0;

        #1;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset in_ready",  64'(in_ready),  64'd1);
        chk("reset out",       64'(out),       64'd0);
        chk("reset flags/err", 64'({flag_zero, flag_carry, flag_ovf, err}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        lit("add wrap",    ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 1, 0, 0, 1);
        lit("add ovf",     ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 0, 1, 0, 1);
        lit("sub borrow",  SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 0, 1, 0, 0, 1);
        lit("sub ovf",     SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 0, 0, 1, 0, 1);
        lit("slt",         SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 0, 0, 0, 0, 1);
        lit("mul 10001sq", MUL, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 0, 1, 0, 0, 32);
        lit("mul carry",   MUL, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 0, 1, 0, 0, 32);
        lit("shl 31",      SHL, 32'h1, 32'd31, 32'h8000_0000, 0, 0, 0, 0, 1);
        lit("shl 32",      SHL, 32'h1, 32'd32, 32'h0, 1, 0, 0, 0, 1);
        lit("sra 40",      SRA, 32'h8000_0000, 32'd40, 32'hFFFF_FFFF, 0, 0, 0, 0, 1);
        lit("shr 31",      SHR, 32'h8000_0000, 32'd31, 32'h1, 0, 0, 0, 0, 1);
        lit("illegal",     4'hF, 32'h1234, 32'h5678, 32'h0, 0, 0, 0, 1, 1);

        // Back-to-back single-cycle ops, one per clock.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            control  = (i == 0) ? AND_ : (i == 1) ? OR_ : (i == 2) ? XOR_ : SUB;
            operand1 = 32'hF0F0_1234 + 32'(i);
            operand2 = 32'h0FF0_4321 * 32'(i + 1);
            @(negedge clk);
            chk("b2b in_ready", 64'(in_ready), 64'd1);
            @(posedge clk);
            #1 chk("b2b out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Consumer stall: result must hold while other ops are offered.
        out_ready = 1'b0;
        send(ADD, 32'h10, 32'h20);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; control = SUB; operand1 = 32'(i); operand2 = 32'h99;
            @(posedge clk);
            #1;
            chk("stall out", 64'({out, flag_zero, flag_carry, flag_ovf, err}), 64'({32'h30, 4'b0000}));
            chk("stall in_ready", 64'({out_valid, in_ready}), 64'b10);
        end
        control = ADD; operand1 = 32'd2; operand2 = 32'd3; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("pass-through out", 64'({out_valid, out}), 64'({1'b1, 32'd5}));
        @(posedge clk);
        #1;

        // Reset during a multiply discards it.
        send(MUL, 32'd3, 32'd5);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("rst mid-mul", 64'({out_valid, in_ready}), 64'b01);
        @(posedge clk);
        #1 rst = 1'b0;
        lit("add after rst", ADD, 32'd7, 32'd8, 32'd15, 0, 0, 0, 0, 1);

        // MUL_STEP=4 instance.
        in_valid4 = 1'b1; control4 = MUL; operand1_4 = 32'h0001_0003; operand2_4 = 32'h0000_0007;
        @(negedge clk);
        chk("step4 in_ready", 64'(in_ready4), 64'd1);
        @(posedge clk);
        #1 in_valid4 = 1'b0;
        lat = 1;
        while (!out_valid4 && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("step4 latency", 64'(lat), 64'd8);
        chk("step4 out", 64'({out4, zero4, carry4, ovf4, err4}), 64'({32'h0007_0015, 4'b0000}));

        repeat (3) @(posedge clk);
        #1 chk("scoreboard drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
